// File: rtl/jtdd_colmix_if.sv
// CPU-side palette bus between the main CPU address decoder and the colour mixer.
interface jtdd_colmix_if;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          cen_Q;
  logic [AW-1:0] cpu_AB;
  logic          pal_cs;
  logic          cpu_wrn;
  logic [DW-1:0] cpu_dout;
  logic [DW-1:0] pal_dout;

  modport master (output cen_Q, cpu_AB, pal_cs, cpu_wrn, cpu_dout, input pal_dout);
  modport slave  (input cen_Q, cpu_AB, pal_cs, cpu_wrn, cpu_dout, output pal_dout);
endinterface

// File: rtl/jtdd_colmix.sv
// Layer priority resolver and palette lookup: char/scroll/object pixels to 4-bit RGB,
// with a CPU read/write port into the RG and B palette RAMs.
module jtdd_colmix #(
  parameter SIMFILE_RG = "pal_rg.bin",
  parameter SIMFILE_B  = "pal_b.bin"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  jtdd_colmix_if.slave cpu,
  input  logic [7:0]  char_pxl,
  input  logic [7:0]  scr_pxl,
  input  logic [7:0]  obj_pxl,
  input  logic [2:0]  gfx_en,
  input  logic        LHBL,
  input  logic        LVBL,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        LHBL_dly,
  output logic        LVBL_dly
);
  localparam int unsigned IW      = 9;
  localparam int unsigned ENTRIES = 512;
  localparam int unsigned RGW     = 8;
  localparam int unsigned BW      = 4;
  localparam logic [IW-1:0] BG_IDX = 9'h100;

  // Preload images belong to the simulation RAM model; the synthesizable arrays start undefined.
  if ((|SIMFILE_RG) && (|SIMFILE_B)) begin : g_preload_hook
  end

  logic [RGW-1:0] rg_ram [ENTRIES];
  logic [BW-1:0]  b_ram  [ENTRIES];

  logic [IW-1:0]  pal_idx, idx_c, cpu_addr;
  logic           lhbl1, lvbl1;
  logic [RGW-1:0] rg_vid;
  logic [BW-1:0]  b_vid;
  logic           char_op, scr_op, obj_op, we_c;
  logic           unused_msb;

  assign char_op    = gfx_en[0] && (char_pxl[3:0] != 4'd0);
  assign scr_op     = gfx_en[1] && (scr_pxl[3:0]  != 4'd0);
  assign obj_op     = gfx_en[2] && (obj_pxl[3:0]  != 4'd0);
  assign we_c       = cpu.cen_Q & cpu.pal_cs & ~cpu.cpu_wrn;
  assign cpu_addr   = cpu.cpu_AB[IW-1:0];
  assign unused_msb = char_pxl[7] ^ obj_pxl[7];

  // Priority: char, high-priority scroll, objects, low-priority scroll, background.
  always_comb begin
    idx_c = BG_IDX;
    if (char_op)                    idx_c = {2'b00, char_pxl[6:0]};
    else if (scr_op && scr_pxl[7])  idx_c = {1'b1, scr_pxl};
    else if (obj_op)                idx_c = {2'b01, obj_pxl[6:0]};
    else if (scr_op)                idx_c = {1'b1, scr_pxl};
  end

  // CPU write port; the video side only reads.
  always_ff @(posedge clk) begin
    if (we_c) begin
      if (cpu.cpu_AB[9]) b_ram[cpu_addr]  <= cpu.cpu_dout[BW-1:0];
      else               rg_ram[cpu_addr] <= cpu.cpu_dout;
    end
  end

  // RAM reads see pre-write contents, so a same-cycle collision returns old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rg_vid       <= '0;
      b_vid        <= '0;
      cpu.pal_dout <= '0;
    end else begin
      rg_vid       <= rg_ram[pal_idx];
      b_vid        <= b_ram[pal_idx];
      cpu.pal_dout <= cpu.cpu_AB[9] ? {4'h0, b_ram[cpu_addr]} : rg_ram[cpu_addr];
    end
  end

  // Two-stage pixel pipeline: index/blank capture, then palette colour out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pal_idx  <= '0;
      lhbl1    <= 1'b0;
      lvbl1    <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      pal_idx  <= idx_c;
      lhbl1    <= LHBL;
      lvbl1    <= LVBL;
      LHBL_dly <= lhbl1;
      LVBL_dly <= lvbl1;
      if (lhbl1 && lvbl1) begin
        red   <= rg_vid[3:0];
        green <= rg_vid[7:4];
        blue  <= b_vid;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_jtdd_colmix.sv
// Randomized bench for jtdd_colmix against a per-pixel palette/priority reference model.
module tb_jtdd_colmix;
  logic       clk = 1'b0;
  logic       rst;
  logic       pxl_cen;
  logic [7:0] char_pxl, scr_pxl, obj_pxl;
  logic [2:0] gfx_en;
  logic       LHBL, LVBL;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  jtdd_colmix_if ifc();

  jtdd_colmix dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cpu(ifc.slave),
    .char_pxl(char_pxl), .scr_pxl(scr_pxl), .obj_pxl(obj_pxl), .gfx_en(gfx_en),
    .LHBL(LHBL), .LVBL(LVBL), .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference state: palette contents plus what each pipeline stage should hold.
  logic [7:0]  m_rg [512];
  logic [3:0]  m_b  [512];
  logic [8:0]  m_idx;
  logic        m_l1, m_v1, m_ld, m_vd;
  logic [7:0]  m_vid_rg, m_dout;
  logic [3:0]  m_vid_b;
  logic [11:0] m_rgb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_idx(input logic [7:0] c, input logic [7:0] s,
                                         input logic [7:0] o, input logic [2:0] en);
    bit co, so, oo;
    co = en[0] && (c % 16 != 0);
    so = en[1] && (s % 16 != 0);
    oo = en[2] && (o % 16 != 0);
    if (co)             return 9'(c % 128);
    if (so && s >= 128) return 9'(256 + s);
    if (oo)             return 9'(128 + o % 128);
    if (so)             return 9'(256 + s);
    return 9'd256;
  endfunction

  task automatic model_reset();
    m_idx = '0; m_l1 = 1'b0; m_v1 = 1'b0; m_ld = 1'b0; m_vd = 1'b0;
    m_vid_rg = '0; m_vid_b = '0; m_rgb = '0; m_dout = '0;
  endtask

  // One clock: capture inputs, advance the model, then compare after the edge.
  task automatic tick();
    logic [8:0] nidx;
    logic       nl, nv, pc, we;
    logic [9:0] a;
    logic [7:0] d, vr;
    logic [3:0] vb;
    nidx = ref_idx(char_pxl, scr_pxl, obj_pxl, gfx_en);
    nl = LHBL; nv = LVBL; pc = pxl_cen;
    we = ifc.cen_Q & ifc.pal_cs & ~ifc.cpu_wrn;
    a  = ifc.cpu_AB; d = ifc.cpu_dout;
    @(posedge clk);
    if (rst) begin
      vr = m_rg[m_idx];
      vb = m_b[m_idx];
      m_dout = a[9] ? {4'h0, m_b[a[8:0]]} : m_rg[a[8:0]];
      if (pc) begin
        m_ld  = m_l1;
        m_vd  = m_v1;
        m_rgb = (m_l1 && m_v1) ? {m_vid_rg[3:0], m_vid_rg[7:4], m_vid_b} : 12'h0;
        m_idx = nidx; m_l1 = nl; m_v1 = nv;
      end
      m_vid_rg = vr;
      m_vid_b  = vb;
    end
    if (we) begin
      if (a[9]) m_b[a[8:0]] = d[3:0];
      else      m_rg[a[8:0]] = d;
    end
    #1;
    if (chk_en) begin
      check("rgb",      32'({red, green, blue}), 32'(m_rgb));
      check("lhbl_dly", 32'(LHBL_dly), 32'(m_ld));
      check("lvbl_dly", 32'(LVBL_dly), 32'(m_vd));
      check("pal_dout", 32'(ifc.pal_dout), 32'(m_dout));
    end
  endtask

  task automatic pulse();
    pxl_cen = 1'b1; tick(); pxl_cen = 1'b0;
  endtask

  task automatic set_pix(input logic [7:0] c, input logic [7:0] s, input logic [7:0] o,
                         input logic [2:0] en);
    char_pxl = c; scr_pxl = s; obj_pxl = o; gfx_en = en;
  endtask

  task automatic cpu_op(input logic [9:0] a, input logic [7:0] d, input logic wr,
                        input logic cen);
    ifc.cpu_AB = a; ifc.cpu_dout = d; ifc.cpu_wrn = ~wr; ifc.pal_cs = 1'b1; ifc.cen_Q = cen;
    tick();
    ifc.cpu_wrn = 1'b1; ifc.pal_cs = 1'b0;
  endtask

  task automatic rand_video();
    char_pxl = 8'($urandom); scr_pxl = 8'($urandom); obj_pxl = 8'($urandom);
    if ($urandom_range(3, 0) == 0) char_pxl = char_pxl & 8'hF0;
    if ($urandom_range(3, 0) == 0) scr_pxl  = scr_pxl & 8'hF0;
    if ($urandom_range(3, 0) == 0) obj_pxl  = obj_pxl & 8'hF0;
    gfx_en = ($urandom_range(4, 0) == 0) ? 3'($urandom) : 3'b111;
    LHBL = ($urandom_range(9, 0) != 0);
    LVBL = ($urandom_range(19, 0) != 0);
  endtask

  task automatic rand_cpu();
    ifc.cen_Q    = 1'($urandom);
    ifc.pal_cs   = 1'($urandom);
    ifc.cpu_wrn  = 1'($urandom);
    ifc.cpu_dout = 8'($urandom);
    ifc.cpu_AB   = ($urandom_range(3, 0) == 0) ? {1'($urandom), m_idx} : 10'($urandom);
  endtask

  task automatic mid_reset();
    ifc.cpu_wrn = 1'b1;
    rst = 1'b0;
    #1;
    check("arst_rgb",  32'({red, green, blue}), 32'h0);
    check("arst_lhbl", 32'(LHBL_dly), 32'h0);
    check("arst_lvbl", 32'(LVBL_dly), 32'h0);
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rand_video();
      pxl_cen = ~i[0];
      tick();
    end
    pxl_cen = 1'b0;
    rst = 1'b1;
    LHBL = 1'b1; LVBL = 1'b1;
    pulse();
    check("rel_lhbl_first", 32'(LHBL_dly), 32'h0);
    tick();
    pulse();
    check("rel_lhbl_second", 32'(LHBL_dly), 32'h1);
    tick();
  endtask

  typedef struct packed {
    logic [7:0]  c, s, o;
    logic [2:0]  en;
    logic [11:0] rgb;
  } prio_t;

  prio_t cases [5] = '{
    '{c: 8'h23, s: 8'h81, o: 8'h15, en: 3'b111, rgb: 12'hA53},
    '{c: 8'h20, s: 8'h81, o: 8'h15, en: 3'b111, rgb: 12'hC96},
    '{c: 8'h20, s: 8'h01, o: 8'h15, en: 3'b111, rgb: 12'h74E},
    '{c: 8'h20, s: 8'h00, o: 8'h10, en: 3'b111, rgb: 12'h218},
    '{c: 8'h23, s: 8'h81, o: 8'h15, en: 3'b000, rgb: 12'h218}
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    for (int i = 0; i < 512; i++) begin m_rg[i] = '0; m_b[i] = '0; end
    model_reset();
    ifc.cen_Q = 1'b0; ifc.pal_cs = 1'b0; ifc.cpu_wrn = 1'b1; ifc.cpu_AB = '0; ifc.cpu_dout = '0;
    pxl_cen = 1'b0; rst = 1'b1;
    rand_video();
    #1 rst = 1'b0;

    // Reset with random activity: everything visible stays at zero.
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_video();
      pxl_cen = i[0];
      tick();
      check("rst_rgb", 32'({red, green, blue}), 32'h0);
      check("rst_dly", 32'({LHBL_dly, LVBL_dly}), 32'h0);
    end
    pxl_cen = 1'b0;
    rst = 1'b1;

    // Fill both palettes with the pipeline frozen.
    chk_en = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      d = 8'($urandom);
      case (i)
        'h023: d = 8'h5A;  'h223: d = 8'h03;
        'h181: d = 8'h9C;  'h381: d = 8'hF6;
        'h095: d = 8'h47;  'h295: d = 8'h0E;
        'h100: d = 8'h12;  'h300: d = 8'h58;
        default: ;
      endcase
      cpu_op(10'(i), d, 1'b1, 1'b1);
    end
    tick();
    chk_en = 1'b1;

    // Priority and transparency.
    LHBL = 1'b1; LVBL = 1'b1;
    foreach (cases[k]) begin
      set_pix(cases[k].c, cases[k].s, cases[k].o, cases[k].en);
      pulse(); tick();
      pulse();
      check($sformatf("prio_%0d", k), 32'({red, green, blue}), 32'(cases[k].rgb));
      if (k == 0) check("rel_dly", 32'({LHBL_dly, LVBL_dly}), 32'h3);
      tick();
    end

    // One blanked pixel yields exactly one black pixel with LHBL_dly low.
    set_pix(8'h23, 8'h81, 8'h15, 3'b111);
    pulse(); tick(); pulse(); tick();
    LHBL = 1'b0; pulse();
    check("blank_before", 32'({red, green, blue, LHBL_dly}), 32'h14A7);
    tick();
    LHBL = 1'b1; pulse();
    check("blank_hit", 32'({red, green, blue, LHBL_dly}), 32'h0);
    tick();
    pulse();
    check("blank_after", 32'({red, green, blue, LHBL_dly}), 32'h14A7);
    tick();

    // CPU read/write path.
    cpu_op(10'h044, 8'hC7, 1'b1, 1'b1);
    cpu_op(10'h044, 8'h00, 1'b0, 1'b1);
    check("cpu_rg_rd", 32'(ifc.pal_dout), 32'hC7);
    cpu_op(10'h244, 8'hFF, 1'b1, 1'b1);
    cpu_op(10'h244, 8'h00, 1'b0, 1'b1);
    check("cpu_b_rd", 32'(ifc.pal_dout), 32'h0F);
    cpu_op(10'h044, 8'h11, 1'b1, 1'b0);
    cpu_op(10'h044, 8'h00, 1'b0, 1'b1);
    check("cpu_no_cen", 32'(ifc.pal_dout), 32'hC7);

    // Collision: write lands on the clock the video port fetches entry 0x023.
    set_pix(8'h23, 8'h81, 8'h15, 3'b111);
    pulse();
    cpu_op(10'h023, 8'h33, 1'b1, 1'b1);
    pulse();
    check("coll_old", 32'({red, green, blue}), 32'hA53);
    tick();
    pulse();
    check("coll_new", 32'({red, green, blue}), 32'h333);
    tick();

    // Randomized traffic with a reset in the middle of the frame.
    for (int p = 0; p < 400; p++) begin
      int gap;
      if (p == 200) mid_reset();
      rand_video();
      rand_cpu();
      pulse();
      gap = $urandom_range(3, 1);
      for (int g = 0; g < gap; g++) begin
        rand_cpu();
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jtdd_colmix.md
Name: jtdd_colmix

Overview:
- Colour mixer directly downstream of the scroll layer.
- Takes the per-pixel outputs of the char, scroll and object layers and resolves layer priority into a 9-bit palette index.
- Looks that index up in a CPU-writable palette RAM and drives 4-bit RGB plus delayed blanking to the video output.
- Also owns the CPU read/write path to palette memory.

Parameters:
- SIMFILE_RG, "pal_rg.bin", simulation preload for the red/green palette RAM.
- SIMFILE_B, "pal_b.bin", simulation preload for the blue palette RAM.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- pxl_cen  in  1  pixel clock enable.
- cen_Q  in  1  CPU bus clock enable; qualifies writes.
- cpu_AB  in  10  CPU address. Bit 9: 0 = RG RAM, 1 = B RAM. Bits [8:0] = palette entry.
- pal_cs  in  1  palette chip select.
- cpu_wrn  in  1  CPU write, active-low.
- cpu_dout  in  8  CPU write data.
- pal_dout  out  8  CPU read data. Upper nibble is 0 when reading the B RAM.
- char_pxl  in  8  char pixel, {x, pal[2:0], col[3:0]}.
- scr_pxl  in  8  scroll pixel, {prio, pal[2:0], col[3:0]}.
- obj_pxl  in  8  object pixel, {x, pal[2:0], col[3:0]}.
- gfx_en  in  3  debug layer enables, {obj, scr, char}. 1 = layer shown.
- LHBL  in  1  horizontal blank, active-low.
- LVBL  in  1  vertical blank, active-low.
- red  out  4  pixel red.
- green  out  4  pixel green.
- blue  out  4  pixel blue.
- LHBL_dly  out  1  LHBL delayed to align with RGB.
- LVBL_dly  out  1  LVBL delayed to align with RGB.

Behaviour:
- Reset (rst=0, asynchronous): red, green, blue, pal_dout and all pipeline registers go to 0. LHBL_dly and LVBL_dly go to 0 (blanked). Palette RAM contents are not cleared. Release is synchronous to clk; the first pxl_cen after release starts the pipeline.
- Opacity: a layer is opaque when its col[3:0] != 0 and its gfx_en bit is 1.
- Stage 1 (on pxl_cen) registers the palette index pal_idx[8:0], chosen in this order:
  - char opaque -> {2'b00, char_pxl[6:0]}.
  - else scroll opaque and scr_pxl[7]=1 -> {1'b1, scr_pxl[7:0]} (scroll above objects).
  - else obj opaque -> {2'b01, obj_pxl[6:0]}.
  - else scroll opaque -> {1'b1, scr_pxl[7:0]}.
  - else background -> 9'h100 (scroll palette entry 0).
- Stage 1 also registers LHBL and LVBL.
- Palette RAM: two dual-port RAMs of 512 entries each.
  - RG RAM is 8 bits: [7:4] = green, [3:0] = red.
  - B RAM is 4 bits.
  - Video port reads synchronously at address pal_idx, one clk after pal_idx updates.
  - The video port never writes.
- Stage 2 (on pxl_cen): RGB and the _dly blanking outputs update. If the stage-1 blanking (LHBL&LVBL) is 0, RGB = 0; otherwise RGB = RAM data.
- Total latency: 2 pxl_cen from layer pixel/blank inputs to RGB and _dly outputs. LHBL_dly and LVBL_dly therefore carry the blanking sampled two pxl_cen earlier.
- Requirement: consecutive pxl_cen pulses are at least 2 clk apart, so RAM data is valid at stage 2.
- CPU write: we = cen_Q & pal_cs & ~cpu_wrn. cpu_AB[9] selects the RAM; for the B RAM, cpu_dout[3:0] is stored. One write per qualifying clk.
- CPU read: pal_dout = registered RAM output at cpu_AB[8:0], valid one clk after the address. Selected by cpu_AB[9] as registered alongside the read.
- Simultaneous CPU write and video read of the same entry: the video port returns the old data. The new data is visible on the next read.
- pxl_cen low: all video-side registers hold their values. CPU access is independent of pxl_cen.
- Reset mid-frame: outputs return to 0 immediately. Blanking outputs stay 0 until two pxl_cen after release.

Test Plan:
- Reset: hold rst=0 with random inputs -> red/green/blue=0 and LHBL_dly=LVBL_dly=0. Release, then 2 pxl_cen with LHBL=LVBL=1 -> _dly outputs=1.
- Priority: RG[0x023]=0x5A, B[0x023]=0x3. char_pxl=0x23, obj_pxl=0x15, scr_pxl=0x81, gfx_en=7 -> after 2 pxl_cen, red=0xA, green=0x5, blue=0x3. Then char_pxl=0x20 -> index 0x181 (scroll prio beats obj). Then scr_pxl=0x01 -> index 0x095 (obj).
- Transparency/background: all col=0 -> index 0x100. RG[0x100]=0x12 -> red=2, green=1. With gfx_en=3'b000 and opaque inputs -> index 0x100.
- Blanking: LHBL=0 for one pxl_cen with opaque char -> exactly one RGB=0 output, 2 pxl_cen later, coincident with LHBL_dly=0.
- CPU access: write 0xC7 at cpu_AB=0x044 with cen_Q=1 -> read back pal_dout=0xC7. Write 0xFF at 0x244 -> pal_dout=0x0F. A write with cen_Q=0 is ignored.
- Collision: CPU writes 0x33 to RG[0x023] in the same clk the video port reads 0x023 -> that pixel shows the old value. The next pixel at index 0x023 shows red=3, green=3.
